// File: rtl/ifmap_skew_feeder.sv
// ifmap_skew_feeder: feeds skewed ifmap rows and the weight word to the PE array edges
module ifmap_skew_feeder #(
  parameter int Data_width = 8,
  parameter int WORD_SIZE  = 72,
  parameter int CNT_W      = 16
) (
  input  logic                 iClk,
  input  logic                 iRest_n,
  input  logic                 iStart,
  input  logic [CNT_W-1:0]     iNum_vec,
  input  logic [WORD_SIZE-1:0] iWeight,
  input  logic [WORD_SIZE-1:0] iIfmap_data,
  input  logic                 iIfmap_valid,
  output logic                 oIfmap_ready,
  output logic [WORD_SIZE-1:0] Weight_f_top,
  output logic                 enable_w,
  output logic                 Run,
  output logic [WORD_SIZE-1:0] oIfmap_left,
  output logic                 oBusy,
  output logic                 oDone
);
  localparam int ROWS = WORD_SIZE / Data_width;
  localparam int DW   = $clog2(ROWS);
  typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0] dcnt;
  logic adv;
  // state register
  always_ff @(posedge iClk or negedge iRest_n)
    if (!iRest_n) state <= IDLE;
    else state <= state_nx;
  // next state and state-decoded strobes; every advance shifts the whole skew pipe
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = iStart ? LOAD_W : IDLE;
      LOAD_W:  state_nx = (cnt != '0) ? STREAM : DONE;
      STREAM:  state_nx = (iIfmap_valid && cnt == CNT_W'(1)) ? DRAIN : STREAM;
      DRAIN:   state_nx = (dcnt == DW'(ROWS - 2)) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
    oIfmap_ready = state == STREAM;
    enable_w     = state == LOAD_W;
    oBusy        = state != IDLE;
    oDone        = state == DONE;
    adv          = (state == STREAM && iIfmap_valid) || state == DRAIN;
  end
  // job bookkeeping: weight/count latch, remaining count, drain length, Run strobe
  always_ff @(posedge iClk or negedge iRest_n)
    if (!iRest_n) begin
      Weight_f_top <= '0;
      cnt          <= '0;
      dcnt         <= '0;
      Run          <= 1'b0;
    end else begin
      Run  <= adv;
      dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
      if (state == IDLE && iStart) begin
        Weight_f_top <= iWeight;
        cnt          <= iNum_vec;
      end
      if (state == STREAM && iIfmap_valid) cnt <= cnt - 1'b1;
    end
  for (genvar k = 0; k < ROWS; k++) begin : g_lane
    logic [Data_width*(k+1)-1:0] sh;
    logic [Data_width-1:0] lane_in;
    assign lane_in = (state == STREAM) ? iIfmap_data[k*Data_width +: Data_width] : '0;
    assign oIfmap_left[k*Data_width +: Data_width] = sh[Data_width*(k+1)-1 -: Data_width];
    if (k == 0) begin : g_one
      // lane 0 is a single register
      always_ff @(posedge iClk or negedge iRest_n)
        if (!iRest_n) sh <= '0;
        else if (adv) sh <= lane_in;
    end else begin : g_chain
      // lane k delays its byte by k extra advances
      always_ff @(posedge iClk or negedge iRest_n)
        if (!iRest_n) sh <= '0;
        else if (adv) sh <= {sh[Data_width*k-1:0], lane_in};
    end
  end
endmodule
